// File: rtl/irq_aggregator_pkg.sv
// Shared constants for the interrupt aggregator: register word addresses and the widest supported input count.
// Latency: none, declarations only.
// Backpressure: not applicable.
package irq_aggregator_pkg;

   localparam int MAX_IRQ = 16;

   localparam logic [2:0] ADDR_PENDING  = 3'd0;
   localparam logic [2:0] ADDR_MASK     = 3'd1;
   localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
   localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
   localparam logic [2:0] ADDR_VECTOR   = 3'd4;
   localparam logic [2:0] ADDR_FORCE    = 3'd5;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [3:0] lowest_index(input logic [MAX_IRQ-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = MAX_IRQ - 1; i >= 0; i--) begin
         if (v[i]) idx = i[3:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_aggregator_sync.sv
// Two-flop bit synchroniser bringing an asynchronous interrupt line into the clk domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running.
module irq_aggregator_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the input through two flops to let metastability resolve.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator with Avalon-MM register map (pending/mask/edge-select/active/vector/force); optional IRQ_AGGREGATOR_SYNC_EN adds input synchronisers.
// Latency: input to PENDING 2 edges (4 with sync), PENDING to irq_out 1 edge, read data 1 cycle.
// Backpressure: none; slave accepts every access, reads have no side effects.
module irq_aggregator
   import irq_aggregator_pkg::*;
#(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               chipselect,
   input  logic [2:0]         address,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   output logic               irq_out
);

   // Bits at or above NUM_IRQ are held at zero everywhere.
   localparam logic [MAX_IRQ-1:0] VALID = MAX_IRQ'((32'd1 << NUM_IRQ) - 32'd1);

   logic [MAX_IRQ-1:0] irq_ext;
   logic [MAX_IRQ-1:0] s_q;
   logic [MAX_IRQ-1:0] prev_q;
   logic [MAX_IRQ-1:0] mask_q;
   logic [MAX_IRQ-1:0] edge_sel_q;
   logic [MAX_IRQ-1:0] latch_q;
   logic [MAX_IRQ-1:0] latch_nxt;
   logic [MAX_IRQ-1:0] wdata_v;
   logic [MAX_IRQ-1:0] w1c;
   logic [MAX_IRQ-1:0] force_set;
   logic [MAX_IRQ-1:0] rise;
   logic [MAX_IRQ-1:0] pending;
   logic [MAX_IRQ-1:0] active;
   logic [15:0]        vector;
   logic [15:0]        rd_mux;
   logic               wr_en;

`ifdef IRQ_AGGREGATOR_SYNC_EN
   logic [NUM_IRQ-1:0] sync_q;

   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
      irq_aggregator_sync u_sync (
         .clk     (clk),
         .reset_n (reset_n),
         .d       (irq_in[i]),
         .q       (sync_q[i])
      );
   end

   assign irq_ext = MAX_IRQ'(sync_q);
`else
   assign irq_ext = MAX_IRQ'(irq_in);
`endif

   assign wr_en     = chipselect & ~write_n;
   assign wdata_v   = writedata & VALID;
   assign w1c       = (wr_en && address == ADDR_PENDING) ? wdata_v : '0;
   assign force_set = (wr_en && address == ADDR_FORCE)   ? wdata_v : '0;
   assign rise      = s_q & ~prev_q;

   // Level bits mirror the sampled input; edge bits show their latch.
   assign pending = (latch_q & edge_sel_q) | (s_q & ~edge_sel_q);
   assign active  = pending & mask_q;
   assign vector  = {|active, 11'd0, lowest_index(active)};

   // Sample the inputs once and keep the previous sample for rise detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_q    <= '0;
         prev_q <= '0;
      end else begin
         s_q    <= irq_ext & VALID;
         prev_q <= s_q;
      end
   end

   // Software-writable configuration registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q     <= '0;
         edge_sel_q <= '0;
      end else if (wr_en) begin
         if (address == ADDR_MASK)     mask_q     <= wdata_v;
         if (address == ADDR_EDGE_SEL) edge_sel_q <= wdata_v;
      end
   end

   // Edge latch next state: set beats W1C, and leaving edge mode drops the latch.
   always_comb begin
      latch_nxt = ((latch_q & ~w1c) | rise | force_set) & edge_sel_q;
      if (wr_en && address == ADDR_EDGE_SEL) latch_nxt = latch_nxt & wdata_v;
   end

   // Hold the edge latches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) latch_q <= '0;
      else          latch_q <= latch_nxt;
   end

   // Read mux; write-only and unmapped addresses return zero.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_PENDING:  rd_mux = pending;
         ADDR_MASK:     rd_mux = mask_q;
         ADDR_EDGE_SEL: rd_mux = edge_sel_q;
         ADDR_ACTIVE:   rd_mux = active;
         ADDR_VECTOR:   rd_mux = vector;
         default:       rd_mux = '0;
      endcase
   end

   // Register read data and the aggregated interrupt every edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         irq_out  <= 1'b0;
      end else begin
         readdata <= rd_mux;
         irq_out  <= |active;
      end
   end

endmodule
